// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state codes and
// a helper that sizes the bit counter.
package serial_sub_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

  // A one-bit operand still needs a one-bit counter, so clamp at 1.
  function automatic int cntWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/half_sub_cell.sv
// Combinational half subtractor: difference and borrow of x - y.
module half_sub_cell (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor: one full-subtract bit per cycle, LSB first,
// with start/done handshake, synchronous abort and a held result.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  localparam int CW = cntWidth(W);
  localparam logic [CW-1:0] LastBit = CW'(W - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [W-1:0]       aSr_q, aSr_d;
  logic [W-1:0]       bSr_q, bSr_d;
  logic [W-1:0]       diff_q, diff_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               borrowOut_q, borrowOut_d;

  logic d1, b1, dbit, b2, bout;

  // Two half subtractors chained through the borrow flop form the full-subtract bit.
  half_sub_cell u_hsLo (
    .x  (aSr_q[0]),
    .y  (bSr_q[0]),
    .d  (d1),
    .bo (b1)
  );

  half_sub_cell u_hsHi (
    .x  (d1),
    .y  (borrow_q),
    .d  (dbit),
    .bo (b2)
  );

  assign bout = b1 | b2;

  always_comb begin
    state_d     = state_q;
    aSr_d       = aSr_q;
    bSr_d       = bSr_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    borrowOut_d = borrowOut_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          aSr_d    = a;
          bSr_d    = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Abort leaves the partial result untouched; the requester must ignore it.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          diff_d         = diff_q >> 1;
          diff_d[W-1]    = dbit;
          aSr_d          = aSr_q >> 1;
          bSr_d          = bSr_q >> 1;
          borrow_d       = bout;
          if (cnt_q == LastBit) begin
            cnt_d       = '0;
            borrowOut_d = bout;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      aSr_q       <= '0;
      bSr_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      borrowOut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aSr_q       <= aSr_d;
      bSr_q       <= bSr_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      borrowOut_q <= borrowOut_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrowOut_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at W=4, W=1 and W=8, with a
// scoreboard of expected {borrow, diff} pushed at start and popped at done.
module tb_serial_sub_ctrl;

  logic clk;
  logic rst_n;

  logic       start4, abort4, busy4, done4, bo4;
  logic [3:0] a4, b4, diff4;
  logic       start1, abort1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;
  logic       start8, abort8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;

  logic [4:0] sb4[$];
  logic [1:0] sb1[$];
  logic [8:0] sb8[$];

  int checks = 0;
  int failures = 0;
  int doneCnt4 = 0;

  serial_sub_ctrl #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  serial_sub_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  serial_sub_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done4 === 1'b1) doneCnt4++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic doneOf(input int which);
    case (which)
      1:       return done1;
      8:       return done8;
      default: return done4;
    endcase
  endfunction

  function automatic logic busyOf(input int which);
    case (which)
      1:       return busy1;
      8:       return busy8;
      default: return busy4;
    endcase
  endfunction

  // Drives a one-cycle start and returns at the negedge after the sampling edge.
  task automatic startOp(input int which, input logic [7:0] av, input logic [7:0] bv, input bit push);
    @(negedge clk);
    case (which)
      1: begin
        a1 = av[0]; b1 = bv[0]; start1 = 1'b1;
        if (push) sb1.push_back({(av[0] < bv[0]), 1'(av[0] - bv[0])});
      end
      8: begin
        a8 = av; b8 = bv; start8 = 1'b1;
        if (push) sb8.push_back({(av < bv), 8'(av - bv)});
      end
      default: begin
        a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1;
        if (push) sb4.push_back({(av[3:0] < bv[3:0]), 4'(av[3:0] - bv[3:0])});
      end
    endcase
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
  endtask

  // Latency counts negedges after the sampling edge, so done after edge k+W gives W+1.
  task automatic waitDone(input int which, output int lat, output int busyCyc, output bit timedOut);
    lat = 1; busyCyc = 0; timedOut = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (doneOf(which) === 1'b1) begin
        timedOut = 1'b0;
        break;
      end
      if (busyOf(which) === 1'b1) busyCyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done4); end
    checks++; if (diff4 !== 4'd0) begin failures++; $display("[TB] FAIL reset_diff got %0d want 0", diff4); end
    checks++; if (bo4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_borrow got %b want 0", bo4); end
    checks++; if (diff8 !== 8'd0) begin failures++; $display("[TB] FAIL reset_diff8 got %0d want 0", diff8); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, busyCyc;
    bit timedOut;
    logic [4:0] exp4;
    startOp(4, 8'd9, 8'd3, 1'b1);
    waitDone(4, lat, busyCyc, timedOut);
    checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL basic_timeout no done within budget"); end
    checks++; if (lat != 5) begin failures++; $display("[TB] FAIL basic_latency got %0d want 5", lat); end
    checks++; if (busyCyc != 4) begin failures++; $display("[TB] FAIL basic_busy_cycles got %0d want 4", busyCyc); end
    exp4 = (sb4.size() != 0) ? sb4.pop_front() : 5'h1f;
    checks++; if (diff4 !== exp4[3:0]) begin failures++; $display("[TB] FAIL basic_diff got %0d want %0d", diff4, exp4[3:0]); end
    checks++; if (bo4 !== exp4[4]) begin failures++; $display("[TB] FAIL basic_borrow got %b want %b", bo4, exp4[4]); end
    @(negedge clk);
    checks++; if (done4 !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse got %b want 0", done4); end
    repeat (2) @(negedge clk);
    checks++; if (diff4 !== exp4[3:0]) begin failures++; $display("[TB] FAIL basic_diff_held got %0d want %0d", diff4, exp4[3:0]); end
  endtask

  task automatic test_patterns;
    logic [7:0] tblA[5] = '{8'd3, 8'd0, 8'd15, 8'd5, 8'd0};
    logic [7:0] tblB[5] = '{8'd9, 8'd0, 8'd15, 8'd2, 8'd15};
    int lat, busyCyc;
    bit timedOut;
    logic [4:0] exp4;
    for (int i = 0; i < 5; i++) begin
      startOp(4, tblA[i], tblB[i], 1'b1);
      waitDone(4, lat, busyCyc, timedOut);
      checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL pattern%0d_timeout no done", i); end
      exp4 = (sb4.size() != 0) ? sb4.pop_front() : 5'h1f;
      checks++; if (diff4 !== exp4[3:0]) begin failures++; $display("[TB] FAIL pattern%0d_diff got %0d want %0d", i, diff4, exp4[3:0]); end
      checks++; if (bo4 !== exp4[4]) begin failures++; $display("[TB] FAIL pattern%0d_borrow got %b want %b", i, bo4, exp4[4]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int base, lat, busyCyc;
    bit timedOut;
    logic [4:0] exp4;
    base = doneCnt4;
    startOp(4, 8'd9, 8'd3, 1'b1);
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    repeat (2) @(negedge clk);
    start4 = 1'b0;
    waitDone(4, lat, busyCyc, timedOut);
    checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL b2b_timeout no done"); end
    checks++; if (lat != 3) begin failures++; $display("[TB] FAIL b2b_latency got %0d want 3", lat); end
    exp4 = (sb4.size() != 0) ? sb4.pop_front() : 5'h1f;
    checks++; if (diff4 !== exp4[3:0]) begin failures++; $display("[TB] FAIL b2b_diff got %0d want %0d", diff4, exp4[3:0]); end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_start_in_done got busy %b want 0", busy4); end
    repeat (6) @(negedge clk);
    checks++; if (doneCnt4 - base != 1) begin failures++; $display("[TB] FAIL b2b_done_count got %0d want 1", doneCnt4 - base); end
    checks++; if (diff4 !== exp4[3:0]) begin failures++; $display("[TB] FAIL b2b_diff_held got %0d want %0d", diff4, exp4[3:0]); end
  endtask

  task automatic test_abort;
    int base, lat, busyCyc;
    bit timedOut;
    logic [4:0] exp4;
    base = doneCnt4;
    startOp(4, 8'd12, 8'd5, 1'b0);
    repeat (2) @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0) begin failures++; $display("[TB] FAIL abort_done got %b want 0", done4); end
    repeat (6) @(negedge clk);
    checks++; if (doneCnt4 != base) begin failures++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", doneCnt4 - base); end
    // Abort on the last-bit cycle must also suppress done.
    startOp(4, 8'd12, 8'd5, 1'b0);
    repeat (3) @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (doneCnt4 != base) begin failures++; $display("[TB] FAIL abort_last_bit got %0d pulses want 0", doneCnt4 - base); end
    startOp(4, 8'd12, 8'd5, 1'b1);
    waitDone(4, lat, busyCyc, timedOut);
    checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL abort_rerun_timeout no done"); end
    exp4 = (sb4.size() != 0) ? sb4.pop_front() : 5'h1f;
    checks++; if (diff4 !== exp4[3:0]) begin failures++; $display("[TB] FAIL abort_rerun_diff got %0d want %0d", diff4, exp4[3:0]); end
    checks++; if (bo4 !== exp4[4]) begin failures++; $display("[TB] FAIL abort_rerun_borrow got %b want %b", bo4, exp4[4]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int base, lat, busyCyc;
    bit timedOut;
    logic [4:0] exp4;
    base = doneCnt4;
    startOp(4, 8'd8, 8'd1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy4 !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got %b want 0", busy4); end
    checks++; if (diff4 !== 4'd0) begin failures++; $display("[TB] FAIL midreset_diff got %0d want 0", diff4); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (doneCnt4 != base) begin failures++; $display("[TB] FAIL midreset_no_done got %0d pulses want 0", doneCnt4 - base); end
    startOp(4, 8'd8, 8'd1, 1'b1);
    waitDone(4, lat, busyCyc, timedOut);
    checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL midreset_rerun_timeout no done"); end
    exp4 = (sb4.size() != 0) ? sb4.pop_front() : 5'h1f;
    checks++; if (diff4 !== exp4[3:0]) begin failures++; $display("[TB] FAIL midreset_rerun_diff got %0d want %0d", diff4, exp4[3:0]); end
    @(negedge clk);
  endtask

  task automatic test_w1;
    int lat, busyCyc;
    bit timedOut;
    logic [1:0] exp1;
    logic [7:0] tblA[4] = '{8'd0, 8'd1, 8'd1, 8'd0};
    logic [7:0] tblB[4] = '{8'd1, 8'd0, 8'd1, 8'd0};
    for (int i = 0; i < 4; i++) begin
      startOp(1, tblA[i], tblB[i], 1'b1);
      waitDone(1, lat, busyCyc, timedOut);
      checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL w1_%0d_timeout no done", i); end
      checks++; if (lat != 2) begin failures++; $display("[TB] FAIL w1_%0d_latency got %0d want 2", i, lat); end
      exp1 = (sb1.size() != 0) ? sb1.pop_front() : 2'b11;
      checks++; if (diff1 !== exp1[0]) begin failures++; $display("[TB] FAIL w1_%0d_diff got %b want %b", i, diff1, exp1[0]); end
      checks++; if (bo1 !== exp1[1]) begin failures++; $display("[TB] FAIL w1_%0d_borrow got %b want %b", i, bo1, exp1[1]); end
      @(negedge clk);
    end
  endtask

  task automatic test_random_w8;
    int lat, busyCyc;
    bit timedOut;
    logic [8:0] exp8;
    logic [7:0] av, bv;
    for (int i = 0; i < 36; i++) begin
      case (i)
        0:       begin av = 8'd0;   bv = 8'd255; end
        1:       begin av = 8'd255; bv = 8'd0;   end
        2:       begin av = 8'd128; bv = 8'd128; end
        default: begin av = 8'($urandom_range(0, 255)); bv = 8'($urandom_range(0, 255)); end
      endcase
      startOp(8, av, bv, 1'b1);
      waitDone(8, lat, busyCyc, timedOut);
      checks++; if (timedOut !== 1'b0) begin failures++; $display("[TB] FAIL w8_%0d_timeout no done", i); end
      checks++; if (lat != 9) begin failures++; $display("[TB] FAIL w8_%0d_latency got %0d want 9", i, lat); end
      exp8 = (sb8.size() != 0) ? sb8.pop_front() : 9'h1ff;
      checks++; if (diff8 !== exp8[7:0]) begin failures++; $display("[TB] FAIL w8_%0d_diff a=%0d b=%0d got %0d want %0d", i, av, bv, diff8, exp8[7:0]); end
      checks++; if (bo8 !== exp8[8]) begin failures++; $display("[TB] FAIL w8_%0d_borrow a=%0d b=%0d got %b want %b", i, av, bv, bo8, exp8[8]); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; abort1 = 1'b0; a1 = '0; b1 = '0;
    start8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0;
    $display("[TB] starting serial_sub_ctrl bench");
    test_reset;
    test_basic;
    test_patterns;
    test_back_to_back;
    test_abort;
    test_reset_mid_run;
    test_w1;
    test_random_w8;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial W-bit subtractor controller. It reuses a single 1-bit subtract cell (two half subtractors plus a borrow flop) over W cycles to compute a - b, LSB first. It sits between a requesting datapath (start/done handshake) and the shared 1-bit cell, and sequences operand shifting, borrow propagation and result assembly.

Parameters:
W, 4, operand/result width in bits; legal range W >= 1.
CW, $clog2(W) with minimum 1, bit-counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
abort  in  1  synchronous cancel; effective in RUN only
a  in  W  minuend; captured on accepted start
b  in  W  subtrahend; captured on accepted start
busy  out  1  high in RUN
done  out  1  one-cycle pulse when the result is valid
diff  out  W  a - b modulo 2^W; held until the next accepted start
borrow_out  out  1  final borrow (1 when a < b unsigned); held with diff

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, bit counter=0, borrow flop=0, operand shift registers=0.
- States: IDLE, RUN, DONE; encoding is free.
- IDLE: if start=1 at an edge, capture a and b into shift registers, clear the borrow flop and counter, and go to RUN. busy rises in the next cycle. diff and borrow_out keep their old values until the first RUN update.
- RUN: each cycle the cell sees abit=a_sr[0], bbit=b_sr[0], bin=borrow flop.
  - d1 = abit ^ bbit; b1 = ~abit & bbit
  - dbit = d1 ^ bin; b2 = ~d1 & bin; bout = b1 | b2
- RUN clock edge:
  - shift dbit into diff MSB (diff shifts right), shift a_sr and b_sr right, borrow flop = bout, counter += 1.
  - When counter == W-1 at that edge, go to DONE and load borrow_out = bout.
- Latency: with start sampled at edge k, bit i is processed in the cycle after edge k+i. Edge k+W enters DONE. done=1 for exactly the one cycle after edge k+W. The start-to-done latency is W+1 edges.
- DONE: done=1 and busy=0. Next edge returns to IDLE with done=0. A start asserted in DONE is ignored; the requester retries in IDLE.
- start while busy: ignored, with no effect on operands or the sequence.
- abort=1 in RUN: at the next edge go to IDLE with busy=0. No done is issued, and diff/borrow_out hold their partial values, which are undefined for the requester. abort in IDLE or DONE has no effect. If abort and the last-bit edge coincide, abort wins: no DONE, no done pulse.
- Reset mid-RUN: immediate return to the reset values; no done pulse.
- W=1: a single RUN cycle, then DONE.
- Wrap-around: the result is modulo 2^W and borrow_out reports underflow; the counter never exceeds W-1.

Decomposition:
- Package serial_sub_pkg: state enum (IDLE, RUN, DONE) and state-width constant.
- Sub-module half_sub_cell: combinational inputs x, y; outputs d = x ^ y and bo = ~x & y. serial_sub_ctrl instantiates it twice to form the full-subtract bit.
- The FSM, counter and shift registers stay in serial_sub_ctrl.

Test Plan:
- W=4, a=9, b=3, start for 1 cycle -> busy for 4 cycles; done pulses on the 5th edge after start; diff=6; borrow_out=0.
- W=4, a=3, b=9 -> diff=4'b1010 (10); borrow_out=1. Also a=0, b=0 -> diff=0, borrow_out=0. Also a=15, b=15 -> diff=0, borrow_out=0.
- W=4, a=9, b=3, with start re-asserted (a=1, b=1) during RUN and in DONE -> result is still diff=6; exactly one done pulse; no second run.
- abort at RUN bit 2 of a=12, b=5 -> IDLE next edge, busy=0, no done. A following start with a=12, b=5 -> diff=7, borrow_out=0.
- rst_n low mid-RUN for 1 cycle -> outputs go to 0 asynchronously and no done. A new start with a=8, b=1 -> diff=7.
- W=1: a=0, b=1 -> done 2 edges after start; diff=1; borrow_out=1. W=8 exhaustive random against (a-b) mod 256 and (a<b).
